// File: rtl/spinnaker_link_receiver_pkg.sv
// spinnaker_link_receiver_pkg: packet field layout, 2-of-7 code table and symbol decode helper
package spinnaker_link_receiver_pkg;
  localparam int PKT_W = 72;
  localparam int PKT_HDR_LSB = 0;
  localparam int PKT_HDR_W = 8;
  localparam int PKT_KEY_LSB = 8;
  localparam int PKT_KEY_W = 32;
  localparam int PKT_PLD_LSB = 40;
  localparam int PKT_PLD_W = 32;
  localparam int SHORT_NIBBLES = 10;
  localparam int LONG_NIBBLES = 18;
  localparam logic [6:0] EOP_SYM = 7'b1100000;
  localparam logic [6:0] SYM_TAB [16] = '{
    7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
    7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09
  };
  typedef enum logic [1:0] {SYM_NONE, SYM_DATA, SYM_EOP, SYM_ERR} sym_kind_t;
  typedef struct packed {
    logic ok;
    logic [3:0] nib;
  } sym_t;
  function automatic sym_t decode_sym(input logic [6:0] chg);
    decode_sym = '0;
    for (int i = 0; i < 16; i++)
      if (chg == SYM_TAB[i]) decode_sym = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/spinnaker_link_sync.sv
// spinnaker_link_sync: two-flop per-bit synchronizer, output is input delayed by two clocks
module spinnaker_link_sync #(
  parameter int SIZE = 7
) (
  input  logic            clk,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] dout
);
  logic [SIZE-1:0] meta;
  always_ff @(posedge clk) begin
    meta <= din;
    dout <= meta;
  end
endmodule

// File: rtl/spinnaker_link_receiver.sv
// spinnaker_link_receiver: 2-of-7 NRZ link receiver assembling short/long packets onto a valid/ready port
module spinnaker_link_receiver
  import spinnaker_link_receiver_pkg::*;
(
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic [6:0]           SL_DATA_2OF7_IN,
  output logic                 SL_ACK_OUT,
  output logic [PKT_W-1:0]     PKT_DATA_OUT,
  output logic                 PKT_VLD_OUT,
  input  logic                 PKT_RDY_IN
);
  logic [6:0] data, prev, chg;
  logic [PKT_W-1:0] pkt_q;
  logic [4:0] cnt;
  logic err, long_pkt, eop_ok, space, accept;
  sym_t dec;
  sym_kind_t kind;
  spinnaker_link_sync #(.SIZE(7)) u_sync (
    .clk  (CLK_IN),
    .din  (SL_DATA_2OF7_IN),
    .dout (data)
  );
  assign chg = data ^ prev;
  assign dec = decode_sym(chg);
  always_comb
    kind = $countones(chg) < 2 ? SYM_NONE :
           chg == EOP_SYM ? SYM_EOP :
           ($countones(chg) == 2 && dec.ok) ? SYM_DATA : SYM_ERR;
  assign long_pkt = pkt_q[PKT_HDR_LSB+1];
  assign eop_ok = !err && cnt == (long_pkt ? 5'(LONG_NIBBLES) : 5'(SHORT_NIBBLES));
  assign space = !PKT_VLD_OUT || PKT_RDY_IN;
  // a well-formed EOP without output space stays pending: no ack, prev held
  assign accept = kind != SYM_NONE && !(kind == SYM_EOP && eop_ok && !space);
  always_ff @(posedge CLK_IN)
    if (RESET_IN) begin
      prev <= '0;
      pkt_q <= '0;
      cnt <= '0;
      err <= 1'b0;
      SL_ACK_OUT <= 1'b0;
      PKT_DATA_OUT <= '0;
      PKT_VLD_OUT <= 1'b0;
    end else begin
      if (PKT_RDY_IN) PKT_VLD_OUT <= 1'b0;
      if (accept) begin
        prev <= data;
        SL_ACK_OUT <= !SL_ACK_OUT;
      end
      if (kind == SYM_DATA) begin
        if (cnt < 5'(LONG_NIBBLES)) begin
          pkt_q[{cnt, 2'b00} +: 4] <= dec.nib;
          cnt <= cnt + 5'd1;
        end else err <= 1'b1;
      end
      if (kind == SYM_ERR) err <= 1'b1;
      if (kind == SYM_EOP && accept) begin
        cnt <= '0;
        err <= 1'b0;
        if (eop_ok) begin
          PKT_DATA_OUT <= long_pkt ? pkt_q : {{PKT_PLD_W{1'b0}}, pkt_q[PKT_PLD_LSB-1:0]};
          PKT_VLD_OUT <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_spinnaker_link_receiver.sv
// tb_spinnaker_link_receiver: directed and randomized link traffic checked against a packet-level model
module tb_spinnaker_link_receiver;
  logic tb_clk, tb_rst, sl_ack, pkt_vld, pkt_rdy;
  logic [6:0] sl_data, link;
  logic [71:0] pkt_data;
  logic ack_ref, ack_last;
  int n_cmp = 0, n_bad = 0, ack_cnt = 0;
  logic [71:0] rx_q[$], exp_q[$];
  bit tx_done;
  logic [6:0] code_tab [16] = '{
    7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
    7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09
  };
  localparam logic [6:0] EOP = 7'h60;

  spinnaker_link_receiver dut (
    .CLK_IN          (tb_clk),
    .RESET_IN        (tb_rst),
    .SL_DATA_2OF7_IN (sl_data),
    .SL_ACK_OUT      (sl_ack),
    .PKT_DATA_OUT    (pkt_data),
    .PKT_VLD_OUT     (pkt_vld),
    .PKT_RDY_IN      (pkt_rdy)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial ack_last = 1'b0;
  always @(negedge tb_clk) begin
    if (sl_ack !== ack_last) ack_cnt <= ack_cnt + 1;
    ack_last <= sl_ack;
    if (!tb_rst && pkt_vld === 1'b1 && pkt_rdy === 1'b1) rx_q.push_back(pkt_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge tb_clk);
      if (sl_ack !== ack_ref) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) ack_ref = sl_ack;
  endtask

  task automatic send_sym(input logic [6:0] code, input bit skew, input int budget, input bit need_ack, output bit ok);
    logic [6:0] lo;
    lo = code & (~code + 7'd1);
    if (skew) begin
      link ^= lo;
      sl_data = link;
      repeat (3) @(posedge tb_clk);
      link ^= code ^ lo;
    end else link ^= code;
    sl_data = link;
    wait_ack(budget, ok);
    if (need_ack) chk("ack", 72'(ok), 72'd1);
    if (ok) #23;
  endtask

  task automatic send_pkt(input logic [71:0] p, input int nn, input int skew_at, input int err_at, input int budget);
    bit ok;
    for (int i = 0; i < nn; i++) begin
      if (i == err_at) send_sym(7'h07, 1'b0, budget, 1'b1, ok);
      send_sym(code_tab[p[4*i +: 4]], i == skew_at, budget, 1'b1, ok);
    end
    send_sym(EOP, 1'b0, budget, 1'b1, ok);
  endtask

  function automatic logic [71:0] make_pkt(input bit lng);
    logic [71:0] p;
    p = {$urandom, $urandom, 8'($urandom)};
    p[1] = lng;
    return p;
  endfunction

  function automatic logic [71:0] exp_of(input logic [71:0] p);
    return p[1] ? p : {32'b0, p[39:0]};
  endfunction

  function automatic int nib_of(input logic [71:0] p);
    return p[1] ? 18 : 10;
  endfunction

  task automatic check_rx(input string tag);
    logic [71:0] e, got;
    repeat (20) @(negedge tb_clk);
    chk({tag, " count"}, 72'(rx_q.size()), 72'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = rx_q.size() > 0 ? rx_q.pop_front() : 'x;
      chk(tag, got, e);
    end
    rx_q.delete();
  endtask

  initial begin
    logic [71:0] p, a, b, got;
    int a0;
    bit ok;
    tb_rst = 1'b1;
    link = '0;
    sl_data = '0;
    pkt_rdy = 1'b1;
    ack_ref = 1'b0;
    repeat (5) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("reset ack", 72'(sl_ack), 72'd0);
    chk("reset vld", 72'(pkt_vld), 72'd0);
    chk("reset data", pkt_data, 72'd0);
    @(posedge tb_clk);
    #1 tb_rst = 1'b0;
    repeat (3) @(posedge tb_clk);

    // directed short packet: hdr 0, key 1
    a0 = ack_cnt;
    p = 72'h100;
    exp_q.push_back(72'h00_0000_0000_0000_0100);
    send_pkt(p, 10, -1, -1, 200);
    check_rx("short");
    chk("short acks", 72'(ack_cnt - a0), 72'd11);

    // directed long packet
    p = {32'hA5A5A5A6, 32'h00000002, 8'h03};
    exp_q.push_back(p);
    send_pkt(p, 18, -1, -1, 200);
    repeat (20) @(negedge tb_clk);
    got = rx_q.size() > 0 ? rx_q[0] : 'x;
    chk("long key", 72'(got[39:8]), 72'h2);
    chk("long payload", 72'(got[71:40]), 72'hA5A5A5A6);
    check_rx("long");

    // skewed arrival of the two bits of one symbol
    a0 = ack_cnt;
    p = make_pkt(1'b0);
    exp_q.push_back(exp_of(p));
    send_pkt(p, 10, 4, -1, 200);
    check_rx("skew");
    chk("skew acks", 72'(ack_cnt - a0), 72'd11);

    // error symbol mid-packet drops the packet
    a0 = ack_cnt;
    send_pkt(make_pkt(1'b0), 10, -1, 3, 200);
    check_rx("errsym drop");
    chk("errsym acks", 72'(ack_cnt - a0), 72'd12);
    p = make_pkt(1'b1);
    exp_q.push_back(exp_of(p));
    send_pkt(p, 18, -1, -1, 200);
    check_rx("after errsym");

    // wrong length
    send_pkt(make_pkt(1'b0), 5, -1, -1, 200);
    check_rx("short len drop");
    send_pkt(make_pkt(1'b1), 10, -1, -1, 200);
    check_rx("long hdr short len drop");
    p = make_pkt(1'b0);
    exp_q.push_back(exp_of(p));
    send_pkt(p, 10, -1, -1, 200);
    check_rx("after wrong len");

    // directed back-pressure: second EOP held until first packet taken
    @(posedge tb_clk);
    #1 pkt_rdy = 1'b0;
    a = make_pkt(1'b0);
    b = make_pkt(1'b1);
    exp_q.push_back(exp_of(a));
    exp_q.push_back(exp_of(b));
    send_pkt(a, 10, -1, -1, 200);
    for (int i = 0; i < 18; i++) send_sym(code_tab[b[4*i +: 4]], 1'b0, 200, 1'b1, ok);
    send_sym(EOP, 1'b0, 50, 1'b0, ok);
    chk("eop withheld", 72'(ok), 72'd0);
    chk("stall vld", 72'(pkt_vld), 72'd1);
    chk("stall data", pkt_data, exp_of(a));
    @(posedge tb_clk);
    #1 pkt_rdy = 1'b1;
    wait_ack(50, ok);
    chk("eop released", 72'(ok), 72'd1);
    #23;
    check_rx("backpressure pair");

    // 26 random packets with ready low for 200 cycles, then random ready
    tx_done = 1'b0;
    @(posedge tb_clk);
    #1 pkt_rdy = 1'b0;
    fork
      begin
        for (int k = 0; k < 26; k++) begin
          p = make_pkt(1'($urandom));
          exp_q.push_back(exp_of(p));
          send_pkt(p, nib_of(p), -1, -1, 1000);
        end
        tx_done = 1'b1;
      end
      begin
        repeat (200) @(posedge tb_clk);
        while (!tx_done) begin
          @(posedge tb_clk);
          #1 pkt_rdy = 1'($urandom_range(0, 1));
        end
        pkt_rdy = 1'b1;
      end
    join
    check_rx("burst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
